// File: rtl/mysystem_pio_in_irq.sv
// Avalon-MM parallel input port with per-bit synchronizer, debounce filter,
// edge capture and masked level interrupt.
module mysystem_pio_in_irq #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_MODE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BIT_CLEAR       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam bit          FILTER = (DEBOUNCE_CYCLES > 1);
  localparam int unsigned CW     = FILTER ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned LAST   = FILTER ? DEBOUNCE_CYCLES - 1 : 0;

  logic [WIDTH-1:0] sync0, sync1, stable, stable_next;
  logic [WIDTH-1:0] edge_bits, edge_capture, capture_next, irqmask, mask_next, clr;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic             wr;
  logic [31:0]      unused_wdata;

  assign unused_wdata = writedata;
  assign wr = chipselect & ~write_n;

  // Debounce: a change must persist DEBOUNCE_CYCLES synced cycles before stable follows.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < int'(WIDTH); i++) cnt_next[i] = '0;
    if (!FILTER) begin
      stable_next = sync1;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync1[i] != stable[i]) begin
          if (cnt[i] == CW'(LAST)) begin
            stable_next[i] = sync1[i];
          end else if (cnt[i] != {CW{1'b1}}) begin
            cnt_next[i] = cnt[i] + CW'(1);
          end else begin
            cnt_next[i] = cnt[i];
          end
        end
      end
    end
  end

  // Edge detection on the debounced value; a new edge beats a same-cycle clear.
  always_comb begin
    edge_bits = '0;
    case (EDGE_MODE)
      0:       edge_bits = stable_next & ~stable;
      1:       edge_bits = ~stable_next & stable;
      default: edge_bits = stable_next ^ stable;
    endcase
    clr = '0;
    if (wr && address == 2'd3) clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
    capture_next = (edge_capture & ~clr) | edge_bits;
    mask_next    = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0        <= '0;
      sync1        <= '0;
      stable       <= '0;
      edge_capture <= '0;
      irqmask      <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      sync0        <= in_port;
      sync1        <= sync0;
      stable       <= stable_next;
      edge_capture <= capture_next;
      irqmask      <= mask_next;
      irq          <= |(capture_next & mask_next);
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= cnt_next[i];
      case (address)
        2'd0:    readdata <= 32'(stable);
        2'd1:    readdata <= '0;
        2'd2:    readdata <= 32'(irqmask);
        default: readdata <= 32'(edge_capture);
      endcase
    end
  end

endmodule

// File: tb/tb_mysystem_pio_in_irq.sv
// Directed bench: instance a (D=1, rising, bit clear) and instance b
// (D=4, any edge, clear-all) share one stimulus bus.
module tb_mysystem_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mysystem_pio_in_irq #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(1), .BIT_CLEAR(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a));

  mysystem_pio_in_irq #(.WIDTH(8), .EDGE_MODE(2), .DEBOUNCE_CYCLES(4), .BIT_CLEAR(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_b), .irq(irq_b));

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_port = '0; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL reset_irq_a got=%b exp=0", irq_a); end
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL reset_irq_b got=%b exp=0", irq_b); end
    total++; if (readdata_a !== 32'h0) begin bad++; $display("FAIL reset_rd_a got=%h exp=0", readdata_a); end
    total++; if (readdata_b !== 32'h0) begin bad++; $display("FAIL reset_rd_b got=%h exp=0", readdata_b); end
  endtask

  task automatic test_latency_d1();
    do_reset();
    bus_write(2'd2, 32'h1);
    in_port = 8'h01;
    tick(2);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL d1_irq_clk2 got=%b exp=0", irq_a); end
    tick();
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL d1_irq_clk3 got=%b exp=1", irq_a); end
    address = 2'd3;
    tick();
    total++; if (readdata_a !== 32'h1) begin bad++; $display("FAIL d1_read_cap got=%h exp=00000001", readdata_a); end
  endtask

  task automatic test_debounce();
    do_reset();
    bus_write(2'd2, 32'hFF);
    address = 2'd3;
    in_port = 8'h04;
    tick(3);
    in_port = 8'h00;
    tick(8);
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL glitch_irq got=%b exp=0", irq_b); end
    total++; if (readdata_b !== 32'h0) begin bad++; $display("FAIL glitch_cap got=%h exp=0", readdata_b); end
    address = 2'd0;
    tick();
    total++; if (readdata_b !== 32'h0) begin bad++; $display("FAIL glitch_stable got=%h exp=0", readdata_b); end
    in_port = 8'h04;
    tick(5);
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL d4_irq_clk5 got=%b exp=0", irq_b); end
    tick();
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL d4_irq_clk6 got=%b exp=1", irq_b); end
    tick();
    total++; if (readdata_b !== 32'h4) begin bad++; $display("FAIL d4_stable got=%h exp=00000004", readdata_b); end
  endtask

  task automatic test_clear();
    do_reset();
    in_port = 8'h05;
    tick(8);
    address = 2'd3;
    tick();
    total++; if (readdata_a !== 32'h5) begin bad++; $display("FAIL clr_pre_a got=%h exp=00000005", readdata_a); end
    total++; if (readdata_b !== 32'h5) begin bad++; $display("FAIL clr_pre_b got=%h exp=00000005", readdata_b); end
    bus_write(2'd3, 32'hFFFF_FF04);
    tick();
    total++; if (readdata_a !== 32'h1) begin bad++; $display("FAIL clr_bit_a got=%h exp=00000001", readdata_a); end
    total++; if (readdata_b !== 32'h0) begin bad++; $display("FAIL clr_all_b got=%h exp=0", readdata_b); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL clr_irq_nomask got=%b exp=0", irq_a); end
  endtask

  task automatic test_edge_vs_clear();
    do_reset();
    bus_write(2'd2, 32'h1);
    in_port = 8'h01;
    tick(2);
    bus_write(2'd3, 32'h1);
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL race_irq got=%b exp=1", irq_a); end
    address = 2'd3;
    tick();
    total++; if (readdata_a !== 32'h1) begin bad++; $display("FAIL race_cap got=%h exp=00000001", readdata_a); end
    bus_write(2'd3, 32'h1);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL race_later_clr got=%b exp=0", irq_a); end
  endtask

  task automatic test_any_edge();
    do_reset();
    bus_write(2'd2, 32'h8);
    in_port = 8'h08;
    tick(5);
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL any_rise_early got=%b exp=0", irq_b); end
    tick();
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL any_rise got=%b exp=1", irq_b); end
    bus_write(2'd3, 32'h0);
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL any_sw_clear got=%b exp=0", irq_b); end
    in_port = 8'h00;
    tick(5);
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL any_fall_early got=%b exp=0", irq_b); end
    tick();
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL any_fall got=%b exp=1", irq_b); end
    tick();
    total++; if (readdata_b !== 32'h8) begin bad++; $display("FAIL any_cap got=%h exp=00000008", readdata_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_port = 8'hFF;
    bus_write(2'd2, 32'hFF);
    tick(7);
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL rm_pre_irq got=%b exp=1", irq_b); end
    in_port = 8'h80;
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL rm_async_irq got=%b exp=0", irq_b); end
    total++; if (readdata_b !== 32'h0) begin bad++; $display("FAIL rm_async_rd got=%h exp=0", readdata_b); end
    tick();
    reset_n = 1'b1;
    bus_write(2'd2, 32'hFF);
    address = 2'd3;
    tick(4);
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL rm_irq_clk5 got=%b exp=0", irq_b); end
    tick();
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL rm_irq_clk6 got=%b exp=1", irq_b); end
    tick();
    total++; if (readdata_b !== 32'h80) begin bad++; $display("FAIL rm_cap got=%h exp=00000080", readdata_b); end
  endtask

  initial begin
    test_reset();
    test_latency_d1();
    test_debounce();
    test_clear();
    test_edge_vs_clear();
    test_any_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
